// File: rtl/mem_lsu_pkg.sv
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Shared types and constants for the mem_lsu data-memory unit:
//               generic 32/8-bit word types, the i_type operation code and
//               the lsu_err_e response error code.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_lsu_pkg;

   typedef logic [31:0] wires32;
   typedef logic [7:0]  wires8;

   // Operation codes shared with the execution units; the LSU serves only
   // the load/store subset (codes 16..18, 20..21, 24..26).
   typedef enum logic [4:0] {
      ADD  = 5'd0,
      SUB  = 5'd1,
      AND  = 5'd2,
      OR   = 5'd3,
      XOR  = 5'd4,
      SLL  = 5'd5,
      SRL  = 5'd6,
      SRA  = 5'd7,
      SLT  = 5'd8,
      SLTU = 5'd9,
      LB   = 5'd16,
      LH   = 5'd17,
      LW   = 5'd18,
      LBU  = 5'd20,
      LHU  = 5'd21,
      SB   = 5'd24,
      SH   = 5'd25,
      SW   = 5'd26
   } i_type;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_ALIGN = 2'd1,
      ERR_RANGE = 2'd2,
      ERR_OP    = 2'd3
   } lsu_err_e;

   localparam int unsigned MEM_LSU_DEF_BYTES   = 131072;
   localparam int unsigned MEM_LSU_DEF_LATENCY = 1;

endpackage

`default_nettype wire

// File: rtl/mem_lsu_align.sv
// ============================================================================
// Module      : mem_lsu_align
// Description : Combinational lane logic for mem_lsu. Decodes the operation,
//               flags misalignment, builds byte-lane write enables with the
//               store data shifted onto its lanes, and extracts/extends the
//               load result from the addressed storage word.
// Ports       : op         - i_type operation code
//               addr_lo    - byte address bits [1:0]
//               wdata      - raw store data
//               rdata_word - storage word containing the addressed byte
//               is_load/is_store - op is a supported load/store
//               align_err  - halfword/word access not naturally aligned
//               byte_en    - per-lane write enables
//               wdata_sh   - store data placed on its byte lanes
//               load_data  - sign/zero-extended load result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [4:0] op,
   input  logic [1:0] addr_lo,
   input  wires32     wdata,
   input  wires32     rdata_word,
   output logic       is_load,
   output logic       is_store,
   output logic       align_err,
   output logic [3:0] byte_en,
   output wires32     wdata_sh,
   output wires32     load_data
);

   wires32      rd_sh;
   wires8       rd_byte;
   logic [15:0] rd_half;

   // Move the addressed byte/halfword down to bit 0 for extraction.
   assign rd_sh    = rdata_word >> {addr_lo, 3'b000};
   assign rd_byte  = rd_sh[7:0];
   assign rd_half  = rd_sh[15:0];
   assign wdata_sh = wdata << {addr_lo, 3'b000};

   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      align_err = 1'b0;
      byte_en   = 4'b0000;
      load_data = '0;
      case (op)
         LB: begin
            is_load   = 1'b1;
            load_data = {{24{rd_byte[7]}}, rd_byte};
         end
         LBU: begin
            is_load   = 1'b1;
            load_data = {24'h0, rd_byte};
         end
         LH: begin
            is_load   = 1'b1;
            align_err = addr_lo[0];
            load_data = {{16{rd_half[15]}}, rd_half};
         end
         LHU: begin
            is_load   = 1'b1;
            align_err = addr_lo[0];
            load_data = {16'h0, rd_half};
         end
         LW: begin
            is_load   = 1'b1;
            align_err = |addr_lo;
            load_data = rdata_word;
         end
         SB: begin
            is_store = 1'b1;
            byte_en  = 4'b0001 << addr_lo;
         end
         SH: begin
            is_store  = 1'b1;
            align_err = addr_lo[0];
            byte_en   = 4'b0011 << addr_lo;
         end
         SW: begin
            is_store  = 1'b1;
            align_err = |addr_lo;
            byte_en   = 4'b1111;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// Module      : mem_lsu
// Description : Byte-addressable little-endian data memory with a valid/ready
//               request/response interface, configurable size, base address
//               and access latency. Executes LB/LBU/LH/LHU/LW/SB/SH/SW and
//               reports op, range and alignment errors.
// Ports       : clk, rstn (async, active-low)
//               req_valid/req_ready, req_op, req_addr, req_wdata
//               resp_valid/resp_ready, resp_rdata, resp_err
//               stat_loads/stat_stores/stat_errs (only with MEM_LSU_STATS_EN)
// Options     : `define MEM_LSU_STATS_EN adds saturating handshake counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_LSU_DEF_BYTES,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned LATENCY   = MEM_LSU_DEF_LATENCY
) (
   input  logic        clk,
   input  logic        rstn,
`ifdef MEM_LSU_STATS_EN
   output logic [31:0] stat_loads,
   output logic [31:0] stat_stores,
   output logic [31:0] stat_errs,
`endif
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err
);

   localparam int unsigned WORDS  = MEM_BYTES / 4;
   localparam int unsigned IW     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] op_q, op_d;
   wires32     addr_q, addr_d;
   wires32     wdata_q, wdata_d;
   wires32     rdata_q, rdata_d;
   lsu_err_e   err_q, err_d;
   logic       req_ready_q, req_ready_d;
   logic       resp_valid_q, resp_valid_d;

   // Storage is word-organised; contents are never reset.
   wires32     mem [WORDS];

   wires32     offset;
   logic       range_err;
   logic [IW-1:0] word_idx;
   wires32     rd_word;
   logic       is_load, is_store, align_err;
   logic [3:0] byte_en;
   wires32     wdata_sh, load_data;
   logic       access;
   lsu_err_e   err_now;
   logic       mem_we;

   // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
   assign offset    = addr_q - BASE_ADDR;
   assign range_err = offset >= MEM_BYTES;
   assign word_idx  = IW'(offset >> 2);
   assign rd_word   = mem[word_idx];

   mem_lsu_align u_align (
      .op         (op_q),
      .addr_lo    (addr_q[1:0]),
      .wdata      (wdata_q),
      .rdata_word (rd_word),
      .is_load    (is_load),
      .is_store   (is_store),
      .align_err  (align_err),
      .byte_en    (byte_en),
      .wdata_sh   (wdata_sh),
      .load_data  (load_data)
   );

   always_comb begin
      if (!(is_load || is_store)) err_now = ERR_OP;
      else if (range_err)         err_now = ERR_RANGE;
      else if (align_err)         err_now = ERR_ALIGN;
      else                        err_now = ERR_NONE;
   end

   assign access = (state_q == WAIT) && (cnt_q == 4'd0);
   assign mem_we = access && is_store && (err_now == ERR_NONE);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d        = req_op;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               cnt_d       = LAT_M1;
               req_ready_d = 1'b0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               err_d        = err_now;
               rdata_d      = (err_now == ERR_NONE && is_load) ? load_data : '0;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end
         end
         RESP: begin
            // Re-acceptance waits a cycle: req_ready rises with the return to IDLE.
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d      = IDLE;
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         op_q         <= 5'd0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         err_q        <= ERR_NONE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_we && byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

`ifdef MEM_LSU_STATS_EN
   logic [31:0] stat_loads_q, stat_loads_d;
   logic [31:0] stat_stores_q, stat_stores_d;
   logic [31:0] stat_errs_q, stat_errs_d;

   always_comb begin
      stat_loads_d  = stat_loads_q;
      stat_stores_d = stat_stores_q;
      stat_errs_d   = stat_errs_q;
      if (resp_valid_q && resp_ready) begin
         if (err_q != ERR_NONE) begin
            if (stat_errs_q != 32'hFFFF_FFFF) stat_errs_d = stat_errs_q + 32'd1;
         end else if (is_load) begin
            if (stat_loads_q != 32'hFFFF_FFFF) stat_loads_d = stat_loads_q + 32'd1;
         end else begin
            if (stat_stores_q != 32'hFFFF_FFFF) stat_stores_d = stat_stores_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_loads_q  <= '0;
         stat_stores_q <= '0;
         stat_errs_q   <= '0;
      end else begin
         stat_loads_q  <= stat_loads_d;
         stat_stores_q <= stat_stores_d;
         stat_errs_q   <= stat_errs_d;
      end
   end

   assign stat_loads  = stat_loads_q;
   assign stat_stores = stat_stores_q;
   assign stat_errs   = stat_errs_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module      : tb_mem_lsu
// Description : Self-checking bench for mem_lsu (1 KiB at 0x1000, latency 3)
//               against a byte-array reference model. Stats checks are
//               included when MEM_LSU_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;
   import mem_lsu_pkg::*;

   localparam int unsigned MB   = 1024;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          LAT  = 3;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_op = 5'd0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
`ifdef MEM_LSU_STATS_EN
   logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_mem [MB];

   always #5 clk = ~clk;

   mem_lsu #(.MEM_BYTES(MB), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rstn       (rstn),
`ifdef MEM_LSU_STATS_EN
      .stat_loads (stat_loads),
      .stat_stores(stat_stores),
      .stat_errs  (stat_errs),
`endif
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   // Reference: byte array, little-endian, error rules applied in order.
   task automatic model(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic [1:0] err);
      int          size;
      bit          ld, st;
      logic [31:0] off, v;
      rd = 32'h0; size = 1; ld = 0; st = 0;
      case (op)
         LB, LBU: begin ld = 1; size = 1; end
         LH, LHU: begin ld = 1; size = 2; end
         LW:      begin ld = 1; size = 4; end
         SB:      begin st = 1; size = 1; end
         SH:      begin st = 1; size = 2; end
         SW:      begin st = 1; size = 4; end
         default: ;
      endcase
      off = addr - BASE;
      if (!ld && !st)                  err = ERR_OP;
      else if (off >= MB)              err = ERR_RANGE;
      else if ((addr % size) != 0)     err = ERR_ALIGN;
      else begin
         err = ERR_NONE;
         if (st) begin
            for (int i = 0; i < size; i++) ref_mem[off + i] = wdata[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
            if (op == LB && v[7])  v = v | 32'hFFFF_FF00;
            if (op == LH && v[15]) v = v | 32'hFFFF_0000;
            rd = v;
         end
      end
   endtask

   // Issue one request and wait (bounded) for resp_valid; lat=-1 on timeout.
   task automatic drive(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat);
      lat = -1;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (resp_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic finish_resp();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic run(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic [1:0] err,
                      output logic [31:0] exp_rd, output logic [1:0] exp_err, output int lat);
      drive(op, addr, wdata, lat);
      rd  = resp_rdata;
      err = resp_err;
      finish_resp();
      model(op, addr, wdata, exp_rd, exp_err);
   endtask

   task automatic test_reset();
      #2 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
      checks++; if (resp_err !== ERR_NONE) begin errors++; $display("FAIL reset_err got %0d exp 0", resp_err); end
`ifdef MEM_LSU_STATS_EN
      checks++; if ({stat_loads, stat_stores, stat_errs} !== 96'h0) begin
         errors++; $display("FAIL reset_stats got %h %h %h exp 0", stat_loads, stat_stores, stat_errs); end
`endif
      @(negedge clk) rstn = 1'b1;
   endtask

   task automatic test_fill();
      logic [31:0] rd, erd, w; logic [1:0] err, eerr; int lat;
      for (int a = 0; a < MB; a += 4) begin
         w = $urandom;
         run(SW, BASE + a, w, rd, err, erd, eerr, lat);
         checks++; if (err !== ERR_NONE || lat != LAT) begin
            errors++; $display("FAIL fill_sw err %0d lat %0d exp 0 %0d", err, lat, LAT); end
      end
   endtask

   task automatic test_load_store();
      logic [31:0] rd, erd; logic [1:0] err, eerr; int lat;
      logic [31:0] exp_rd [4];
      logic [4:0]  ops [4];
      logic [31:0] adr [4];
      ops = '{LB, LBU, LH, LHU};
      adr = '{BASE + 32'h13, BASE + 32'h13, BASE + 32'h12, BASE + 32'h10};
      exp_rd = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
      run(SW, BASE + 32'h10, 32'hDEAD_BEEF, rd, err, erd, eerr, lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL sw_latency got %0d exp %0d", lat, LAT); end
      checks++; if (err !== ERR_NONE || rd !== 32'h0) begin errors++; $display("FAIL sw_resp got %h/%0d exp 0/0", rd, err); end
      run(LW, BASE + 32'h10, 32'h0, rd, err, erd, eerr, lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL lw_latency got %0d exp %0d", lat, LAT); end
      checks++; if (rd !== 32'hDEAD_BEEF || err !== ERR_NONE) begin
         errors++; $display("FAIL lw_deadbeef got %h/%0d exp deadbeef/0", rd, err); end
      for (int i = 0; i < 4; i++) begin
         run(ops[i], adr[i], 32'h0, rd, err, erd, eerr, lat);
         checks++; if (rd !== exp_rd[i] || err !== ERR_NONE) begin
            errors++; $display("FAIL subword_%0d got %h/%0d exp %h/0", i, rd, err, exp_rd[i]); end
      end
   endtask

   task automatic test_misalign();
      logic [31:0] rd, erd; logic [1:0] err, eerr; int lat;
      run(LW, BASE + 32'h11, 32'h0, rd, err, erd, eerr, lat);
      checks++; if (rd !== 32'h0 || err !== ERR_ALIGN) begin errors++; $display("FAIL lw_misalign got %h/%0d exp 0/1", rd, err); end
      run(SH, BASE + 32'h21, 32'h1234, rd, err, erd, eerr, lat);
      checks++; if (rd !== 32'h0 || err !== ERR_ALIGN) begin errors++; $display("FAIL sh_misalign got %h/%0d exp 0/1", rd, err); end
      run(LW, BASE + 32'h20, 32'h0, rd, err, erd, eerr, lat);
      checks++; if (rd !== erd || err !== ERR_NONE) begin errors++; $display("FAIL lw_after_bad_sh got %h/%0d exp %h/0", rd, err, erd); end
   endtask

   task automatic test_range();
      logic [31:0] rd, erd; logic [1:0] err, eerr; int lat;
      run(LW, 32'h13FC, 32'h0, rd, err, erd, eerr, lat);
      checks++; if (rd !== erd || err !== ERR_NONE) begin errors++; $display("FAIL lw_last_word got %h/%0d exp %h/0", rd, err, erd); end
      run(LW, 32'h13FE, 32'h0, rd, err, erd, eerr, lat);
      checks++; if (rd !== 32'h0 || err !== ERR_ALIGN) begin errors++; $display("FAIL lw_end_minus2 got %h/%0d exp 0/1", rd, err); end
      run(LW, 32'h1400, 32'h0, rd, err, erd, eerr, lat);
      checks++; if (rd !== 32'h0 || err !== ERR_RANGE) begin errors++; $display("FAIL lw_past_end got %h/%0d exp 0/2", rd, err); end
      run(LB, 32'h0FFF, 32'h0, rd, err, erd, eerr, lat);
      checks++; if (rd !== 32'h0 || err !== ERR_RANGE) begin errors++; $display("FAIL lb_below_base got %h/%0d exp 0/2", rd, err); end
      run(ADD, BASE + 32'h11, 32'h0, rd, err, erd, eerr, lat);
      checks++; if (rd !== 32'h0 || err !== ERR_OP) begin errors++; $display("FAIL op_add got %h/%0d exp 0/3", rd, err); end
      run(SW, 32'h1400, 32'h5555_5555, rd, err, erd, eerr, lat);
      checks++; if (err !== ERR_RANGE) begin errors++; $display("FAIL sw_past_end got %0d exp 2", err); end
   endtask

   task automatic test_backpressure();
      logic [31:0] erd, rd; logic [1:0] eerr, err; int lat;
      drive(LW, BASE + 32'h10, 32'h0, lat);
      model(LW, BASE + 32'h10, 32'h0, erd, eerr);
      checks++; if (lat != LAT) begin errors++; $display("FAIL bp_latency got %0d exp %0d", lat, LAT); end
      // A competing request while the response is held must be ignored.
      req_valid = 1'b1; req_op = SW; req_addr = BASE + 32'h10; req_wdata = 32'h0BAD_0BAD;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== erd || resp_err !== eerr) begin
            errors++; $display("FAIL bp_hold_%0d got v%b r%b %h/%0d exp v1 r0 %h/%0d",
                               c, resp_valid, req_ready, resp_rdata, resp_err, erd, eerr); end
      end
      req_valid = 1'b0;
      finish_resp();
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release got v%b r%b exp v0 r1", resp_valid, req_ready); end
      run(LW, BASE + 32'h10, 32'h0, rd, err, erd, eerr, lat);
      checks++; if (rd !== erd || err !== ERR_NONE) begin errors++; $display("FAIL bp_ignored_req got %h exp %h", rd, erd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, erd; logic [1:0] err, eerr; int lat;
      @(negedge clk);
      req_valid = 1'b1; req_op = SW; req_addr = BASE + 32'h40; req_wdata = 32'h0000_00AA;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== ERR_NONE) begin
         errors++; $display("FAIL midreset_outputs got r%b v%b %h/%0d exp r1 v0 0/0", req_ready, resp_valid, resp_rdata, resp_err); end
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      run(LW, BASE + 32'h40, 32'h0, rd, err, erd, eerr, lat);
      checks++; if (rd !== erd || err !== ERR_NONE || lat != LAT) begin
         errors++; $display("FAIL midreset_no_write got %h/%0d lat %0d exp %h/0 lat %0d", rd, err, lat, erd, LAT); end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, addr; logic [1:0] err, eerr; int lat; logic [4:0] op;
      logic [4:0] ls_ops [8];
      ls_ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW};
      for (int n = 0; n < 120; n++) begin
         case ($urandom % 10)
            0:       addr = BASE - 1 - ($urandom % 16);
            1:       addr = BASE + MB + ($urandom % 16);
            default: addr = BASE + ($urandom % MB);
         endcase
         if ($urandom % 10 == 0) op = 5'($urandom % 32);
         else                    op = ls_ops[$urandom % 8];
         run(op, addr, $urandom, rd, err, erd, eerr, lat);
         checks++; if (rd !== erd || err !== eerr || lat != LAT) begin
            errors++; $display("FAIL rand_%0d op %0d addr %h got %h/%0d lat %0d exp %h/%0d lat %0d",
                               n, op, addr, rd, err, lat, erd, eerr, LAT); end
      end
   endtask

`ifdef MEM_LSU_STATS_EN
   task automatic test_stats();
      logic [31:0] rd, erd; logic [1:0] err, eerr; int lat;
      @(negedge clk) rstn = 1'b0;
      @(negedge clk) rstn = 1'b1;
      run(LW,  BASE + 32'h10, 32'h0,        rd, err, erd, eerr, lat);
      run(SW,  BASE + 32'h50, 32'h1111_2222, rd, err, erd, eerr, lat);
      run(LB,  BASE + 32'h51, 32'h0,        rd, err, erd, eerr, lat);
      run(SB,  BASE + 32'h54, 32'h77,       rd, err, erd, eerr, lat);
      run(LW,  BASE + 32'h11, 32'h0,        rd, err, erd, eerr, lat);
      run(LHU, BASE + 32'h52, 32'h0,        rd, err, erd, eerr, lat);
      checks++; if (stat_loads !== 32'd3) begin errors++; $display("FAIL stat_loads got %0d exp 3", stat_loads); end
      checks++; if (stat_stores !== 32'd2) begin errors++; $display("FAIL stat_stores got %0d exp 2", stat_stores); end
      checks++; if (stat_errs !== 32'd1) begin errors++; $display("FAIL stat_errs got %0d exp 1", stat_errs); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_load_store();
      test_misalign();
      test_range();
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef MEM_LSU_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
